id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. It captures decoded operands, resolves RAW hazards by forwarding from the EX, MEM and WB stages, and inserts bubbles on load-use hazards. It registers `readData1`, `readData2` and `ALUOp` so the ALU sees stable operands for a full cycle. It also carries destination and control fields downstream and counts stall cycles for performance debug.

## Interface
Parameters:
- `DW`, 32: datapath width
- `CNT_W`, 16: stall counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: decode presents an instruction
- `id_ready` out 1: stage accepts this cycle
- `id_rs_addr`, `id_rt_addr` in 5 each: source register numbers
- `id_rs_data`, `id_rt_data` in DW each: register file read data
- `id_imm` in DW: extended immediate
- `id_use_imm` in 1: operand 2 is the immediate
- `id_alu_op` in 3: ALU opcode
- `id_rd_addr` in 5: destination register
- `id_reg_write` in 1: writes a register
- `id_mem_read` in 1: is a load
- `flush` in 1: kill contents (branch/jump redirect)
- `ex_result` in DW: ALU result of the instruction now in EX
- `mem_rd_addr` in 5, `mem_reg_write` in 1, `mem_mem_read` in 1, `mem_result` in DW: MEM-stage producer
- `wb_rd_addr` in 5, `wb_reg_write` in 1, `wb_data` in DW: WB-stage producer
- `ex_valid` out 1: EX holds a real instruction
- `ex_ready` in 1: downstream accepts
- `readData1`, `readData2` out DW: ALU operands
- `ALUOp` out 3: ALU opcode
- `ex_rd_addr` out 5, `ex_reg_write` out 1, `ex_mem_read` out 1: carried control
- `stall_cnt` out CNT_W: saturating count of bubble cycles

## Operation
- Reset: every output register is 0, including `ex_valid`, operands, `ALUOp`, control and `stall_cnt`.
- Advance condition `adv = !ex_valid || ex_ready`.
- A match exists when a producer has `reg_write`, its `rd != 0`, and its `rd` equals the source. EX uses `ex_valid && ex_reg_write`.
- A source counts only if it is used:
  - rs is always used.
  - rt is used only when `id_use_imm == 0`.
- Hazard:
  - A match against EX with `ex_mem_read`, or against MEM with `mem_mem_read`, is a hazard: load data is not ready yet.
- Forwarding priority per operand: EX (`ex_result`), then MEM (`mem_result`), then WB (`wb_data`), then register file data. `rd == 0` never forwards.
- `id_ready = adv && !hazard`.
- Capture on `id_valid && id_ready`:
  - `readData1` takes the forwarded rs value.
  - `readData2` takes `id_imm` if `id_use_imm`, else the forwarded rt value.
  - `ALUOp`, `rd`, `reg_write` and `mem_read` are copied; `ex_valid` becomes 1.
- Bubble: if `adv` is true and either `id_valid == 0` or a hazard is present, then `ex_valid` becomes 0 and the control fields are cleared. Operand registers may hold their old values.
- Hold: if `!adv`, all registers hold.
- Flush, which has the highest priority: `ex_valid`, `ex_reg_write` and `ex_mem_read` become 0 at the next edge, overriding capture and hold.
- `stall_cnt` increments on each edge where `id_valid && hazard && adv` holds. It saturates at all-ones.

## Timing
- Latency is 1 cycle: ID inputs become ALU operands after one edge. The ALU result is combinational in the same EX cycle.
- Load-use:
  - Load in EX with a dependent instruction in ID costs 2 bubbles.
  - Load in MEM costs 1 bubble.
  - The dependent instruction forwards from WB.
- `id_ready` is combinational from the current inputs and state; there is no registered back-pressure.
- Downstream stall with a hazard: the stage holds, no bubble is counted, and `id_ready` stays 0.
- Asserting `rst_n` low mid-operation immediately clears all outputs, asynchronously.

## Configuration
- `ID_EX_FWD_EN` defined: the forwarding network is as above.
- `ID_EX_FWD_EN` undefined:
  - Operands always come from the register file.
  - Any match against EX, MEM or WB is a hazard and stalls until the producer has retired.

## Structure
- Shared package `mips_pkg`:
  - ALU opcode constants: `ALU_ADD`=000 through `ALU_SLT`=111
  - `REG_ZERO`
  - `DW`
- Sub-module `fwd_mux`: one instance per operand. It takes the source address and register file data plus the three producer ports and outputs the value and a load-hazard flag.

## Test plan
- Reset, then `id_valid` with rs=1 (data 5), rt=2 (data 7), op 000 → next cycle `ex_valid`=1, `readData1`=5, `readData2`=7, `ALUOp`=000.
- EX producer has rd=3, reg_write, `ex_result`=0x10; ID uses rs=3 with stale register data 0 → `readData1`=0x10.
- EX and MEM both target rd=4 (EX result 1, MEM result 2); ID uses rs=4 → `readData1`=1.
- Load rd=5 in EX, ID uses rt=5 → `id_ready`=0 for 2 cycles, 2 bubbles, `stall_cnt`=2, then capture from `wb_data`.
- `ex_ready`=0 for 3 cycles with a valid instruction in EX → outputs held; `flush` during the hold → `ex_valid`=0 next cycle.
- rd=0 producer with reg_write and `ex_result`=0xFF; ID uses rs=0 → `readData1`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, ALU opcodes,
// the hard-wired zero register and the producer/source match helper.
package mips_pkg;

  localparam int DW = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // A producer matches a source when it writes a register other than r0
  // and that register is the one being read.
  function automatic logic rd_match(input logic wr, input logic [4:0] rd,
                                    input logic [4:0] src);
    return wr && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: per-operand bypass selection and load-use hazard detection.
// ID_EX_FWD_EN defined   -> value comes from the youngest matching producer
//                           (EX, then MEM, then WB); only pending loads stall.
// ID_EX_FWD_EN undefined -> value always comes from the register file and
//                           any in-flight producer of the source stalls.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [4:0]   src,
  input  logic [W-1:0] rf_data,
  input  logic         ex_wr,
  input  logic [4:0]   ex_rd,
  input  logic         ex_load,
  input  logic [W-1:0] ex_data,
  input  logic         mem_wr,
  input  logic [4:0]   mem_rd,
  input  logic         mem_load,
  input  logic [W-1:0] mem_data,
  input  logic         wb_wr,
  input  logic [4:0]   wb_rd,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] value,
  output logic         hazard
);

  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit  = rd_match(ex_wr, ex_rd, src);
  assign mem_hit = rd_match(mem_wr, mem_rd, src);
  assign wb_hit  = rd_match(wb_wr, wb_rd, src);

`ifdef ID_EX_FWD_EN
  // Pick the youngest producer; a load still in EX or MEM has no data yet.
  always_comb begin
    value  = rf_data;
    hazard = (ex_hit && ex_load) || (mem_hit && mem_load);
    if (ex_hit) begin
      value = ex_data;
    end else if (mem_hit) begin
      value = mem_data;
    end else if (wb_hit) begin
      value = wb_data;
    end
  end
`else
  // Bypass data paths are not built in this configuration.
  logic unused_fwd;
  assign unused_fwd = ^{ex_load, ex_data, mem_load, mem_data, wb_data};

  // Wait for every producer of the source to retire, then read the file.
  always_comb begin
    value  = rf_data;
    hazard = ex_hit || mem_hit || wb_hit;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU. Resolves RAW hazards
// by forwarding (ID_EX_FWD_EN) or by stalling (default), inserts bubbles on
// load-use hazards and counts bubble cycles caused by hazards.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Upstream, id_valid/id_ready; ready may drop while valid is held and the
// producer must keep the instruction stable until it is taken. Downstream,
// ex_valid/ex_ready; the EX contents are held while ex_valid && !ex_ready.
module id_ex_stage #(
  parameter int DW    = mips_pkg::DW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic             id_use_imm,
  input  logic [2:0]       id_alu_op,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic [DW-1:0]    ex_result,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [DW-1:0]    mem_result,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic [DW-1:0]    wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [DW-1:0]    readData1,
  output logic [DW-1:0]    readData2,
  output logic [2:0]       ALUOp,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic [CNT_W-1:0] stall_cnt
);

  import mips_pkg::*;

  logic          adv;
  logic          hazard;
  logic          ex_wr;
  logic          rs_haz, rt_haz;
  logic [DW-1:0] rs_val, rt_val;

  assign adv      = !ex_valid || ex_ready;
  assign ex_wr    = ex_valid && ex_reg_write;
  // rt is only a real source when operand 2 is not the immediate.
  assign hazard   = rs_haz || (!id_use_imm && rt_haz);
  assign id_ready = adv && !hazard;

  fwd_mux #(.W(DW)) u_fwd_rs (
    .src      (id_rs_addr),
    .rf_data  (id_rs_data),
    .ex_wr    (ex_wr),
    .ex_rd    (ex_rd_addr),
    .ex_load  (ex_mem_read),
    .ex_data  (ex_result),
    .mem_wr   (mem_reg_write),
    .mem_rd   (mem_rd_addr),
    .mem_load (mem_mem_read),
    .mem_data (mem_result),
    .wb_wr    (wb_reg_write),
    .wb_rd    (wb_rd_addr),
    .wb_data  (wb_data),
    .value    (rs_val),
    .hazard   (rs_haz)
  );

  fwd_mux #(.W(DW)) u_fwd_rt (
    .src      (id_rt_addr),
    .rf_data  (id_rt_data),
    .ex_wr    (ex_wr),
    .ex_rd    (ex_rd_addr),
    .ex_load  (ex_mem_read),
    .ex_data  (ex_result),
    .mem_wr   (mem_reg_write),
    .mem_rd   (mem_rd_addr),
    .mem_load (mem_mem_read),
    .mem_data (mem_result),
    .wb_wr    (wb_reg_write),
    .wb_rd    (wb_rd_addr),
    .wb_data  (wb_data),
    .value    (rt_val),
    .hazard   (rt_haz)
  );

  // Pipeline register: capture, bubble or hold; flush kills the slot last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      readData1    <= '0;
      readData2    <= '0;
      ALUOp        <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      if (adv) begin
        if (id_valid && !hazard) begin
          ex_valid     <= 1'b1;
          readData1    <= rs_val;
          readData2    <= id_use_imm ? id_imm : rt_val;
          ALUOp        <= id_alu_op;
          ex_rd_addr   <= id_rd_addr;
          ex_reg_write <= id_reg_write;
          ex_mem_read  <= id_mem_read;
        end else begin
          // Bubble: operands keep stale data, control is cleared.
          ex_valid     <= 1'b0;
          ALUOp        <= ALU_ADD;
          ex_rd_addr   <= REG_ZERO;
          ex_reg_write <= 1'b0;
          ex_mem_read  <= 1'b0;
        end
      end
      if (flush) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end
    end
  end

  // Count bubbles caused by hazards; a downstream stall is not a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_valid && hazard && adv && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. Works for both builds (ID_EX_FWD_EN defined or
// not). MEM/WB producer ports are driven by a small emulated pipeline that
// advances whatever the model says is in EX.
module tb_id_ex_stage;

  localparam int DW    = 32;
  localparam int CNT_W = 16;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             id_valid, id_ready;
  logic [4:0]       id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DW-1:0]    id_rs_data, id_rt_data, id_imm;
  logic             id_use_imm, id_reg_write, id_mem_read;
  logic [2:0]       id_alu_op;
  logic             flush;
  logic [DW-1:0]    ex_result;
  logic [4:0]       mem_rd_addr;
  logic             mem_reg_write, mem_mem_read;
  logic [DW-1:0]    mem_result;
  logic [4:0]       wb_rd_addr;
  logic             wb_reg_write;
  logic [DW-1:0]    wb_data;
  logic             ex_valid, ex_ready;
  logic [DW-1:0]    readData1, readData2;
  logic [2:0]       ALUOp;
  logic [4:0]       ex_rd_addr;
  logic             ex_reg_write, ex_mem_read;
  logic [CNT_W-1:0] stall_cnt;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .readData1(readData1), .readData2(readData2), .ALUOp(ALUOp),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_cnt(stall_cnt)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] load_data;

  // Expected contents of the EX slot
  logic             m_valid, m_rw, m_mr;
  logic [2:0]       m_op;
  logic [4:0]       m_rd;
  logic [DW-1:0]    m_rd1, m_rd2;
  logic [CNT_W-1:0] m_cnt;

  // Value a source should see, and whether it must wait.
  function automatic void model_src(input logic [4:0] a, input logic [DW-1:0] rf,
                                    output logic [DW-1:0] v, output logic h);
    logic in_ex, in_mem, in_wb;
    in_ex  = (a != 5'd0) && m_valid && m_rw && (m_rd == a);
    in_mem = (a != 5'd0) && mem_reg_write && (mem_rd_addr == a);
    in_wb  = (a != 5'd0) && wb_reg_write && (wb_rd_addr == a);
    if (FWD) begin
      h = (in_ex && m_mr) || (in_mem && mem_mem_read);
      v = in_ex ? ex_result : in_mem ? mem_result : in_wb ? wb_data : rf;
    end else begin
      h = in_ex || in_mem || in_wb;
      v = rf;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0;
    id_alu_op = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    ex_result = 0; ex_ready = 1; load_data = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_mem_read = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    m_valid = 0; m_rw = 0; m_mr = 0; m_op = 0; m_rd = 0;
    m_rd1 = 0; m_rd2 = 0; m_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One clock: check id_ready before the edge, advance model, check after.
  task automatic cycle(output bit cap);
    logic [DW-1:0] v1, v2;
    logic h1, h2, hz, adv, rdy;
    logic [4:0] n_mrd, n_wrd;
    logic n_mrw, n_mmr, n_wrw;
    logic [DW-1:0] n_mres, n_wdat;
    @(negedge clk);
    model_src(id_rs_addr, id_rs_data, v1, h1);
    model_src(id_rt_addr, id_rt_data, v2, h2);
    hz  = h1 || (!id_use_imm && h2);
    adv = !m_valid || ex_ready;
    rdy = adv && !hz;
    checks++;
    if (id_ready !== rdy) begin
      errors++;
      $display("FAIL id_ready t=%0t got %b exp %b", $time, id_ready, rdy);
    end
    cap = id_valid && rdy;
    if (cap) begin
      exp_q.push_back(v1);
      exp_q.push_back(id_use_imm ? id_imm : v2);
    end
    // emulated downstream pipeline
    n_mrd = 0; n_mrw = 0; n_mmr = 0; n_mres = 0;
    if (m_valid && ex_ready) begin
      n_mrd = m_rd; n_mrw = m_rw; n_mmr = m_mr; n_mres = ex_result;
    end
    n_wrd = mem_rd_addr; n_wrw = mem_reg_write;
    n_wdat = mem_mem_read ? load_data : mem_result;
    @(posedge clk);
    #1;
    if (id_valid && hz && adv && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
    if (adv) begin
      if (cap) begin
        m_valid = 1; m_op = id_alu_op; m_rd = id_rd_addr;
        m_rw = id_reg_write; m_mr = id_mem_read;
        m_rd1 = exp_q.pop_front();
        m_rd2 = exp_q.pop_front();
      end else begin
        m_valid = 0; m_op = 0; m_rd = 0; m_rw = 0; m_mr = 0;
      end
    end
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0;
    end
    mem_rd_addr = n_mrd; mem_reg_write = n_mrw; mem_mem_read = n_mmr; mem_result = n_mres;
    wb_rd_addr = n_wrd; wb_reg_write = n_wrw; wb_data = n_wdat;
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read} !== {m_valid, m_rw, m_mr}) begin
      errors++;
      $display("FAIL ex_ctrl t=%0t got %b%b%b exp %b%b%b", $time,
               ex_valid, ex_reg_write, ex_mem_read, m_valid, m_rw, m_mr);
    end
    checks++;
    if (stall_cnt !== m_cnt) begin
      errors++;
      $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, m_cnt);
    end
    if (m_valid) begin
      checks++;
      if (readData1 !== m_rd1) begin
        errors++;
        $display("FAIL readData1 t=%0t got %0h exp %0h", $time, readData1, m_rd1);
      end
      checks++;
      if (readData2 !== m_rd2) begin
        errors++;
        $display("FAIL readData2 t=%0t got %0h exp %0h", $time, readData2, m_rd2);
      end
      checks++;
      if ({ALUOp, ex_rd_addr} !== {m_op, m_rd}) begin
        errors++;
        $display("FAIL op_rd t=%0t got %0h/%0d exp %0h/%0d", $time, ALUOp, ex_rd_addr, m_op, m_rd);
      end
    end
  endtask

  // Present one instruction and keep it valid until accepted.
  task automatic send(input logic [4:0] rs, input logic [DW-1:0] rsd,
                      input logic [4:0] rt, input logic [DW-1:0] rtd,
                      input logic [DW-1:0] imm, input logic ui, input logic [2:0] op,
                      input logic [4:0] rd, input logic rw, input logic mr,
                      output int waits);
    bit done;
    done = 0; waits = 0;
    id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_imm = imm; id_use_imm = ui; id_alu_op = op; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr; id_valid = 1;
    for (int i = 0; i < 12 && !done; i++) begin
      cycle(done);
      if (!done) waits++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout t=%0t rd=%0d", $time, rd);
    end
    id_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #12;
    checks++;
    if ({ex_valid, readData1, readData2, ALUOp, ex_rd_addr, ex_reg_write,
         ex_mem_read, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d1=%0h d2=%0h op=%0h cnt=%0d exp all zero",
               ex_valid, readData1, readData2, ALUOp, stall_cnt);
    end
    do_reset();
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", id_ready);
    end
  endtask

  task automatic test_basic();
    int w;
    send(5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 3'b000, 5'd6, 1'b1, 1'b0, w);
    checks++;
    if ({ex_valid, readData1, readData2, ALUOp} !== {1'b1, 32'd5, 32'd7, 3'b000}) begin
      errors++;
      $display("FAIL basic got v=%b d1=%0h d2=%0h op=%0h exp v=1 d1=5 d2=7 op=0",
               ex_valid, readData1, readData2, ALUOp);
    end
  endtask

  task automatic test_ex_forward();
    int w;
    logic [DW-1:0] exp;
    send(5'd0, 32'd0, 5'd0, 32'd0, 32'd9, 1'b1, 3'b000, 5'd3, 1'b1, 1'b0, w);
    ex_result = 32'h10;
    send(5'd3, 32'd0, 5'd0, 32'd0, 32'd1, 1'b1, 3'b001, 5'd10, 1'b1, 1'b0, w);
    exp = FWD ? 32'h10 : 32'h0;
    checks++;
    if (readData1 !== exp) begin
      errors++;
      $display("FAIL ex_forward got %0h exp %0h", readData1, exp);
    end
  endtask

  task automatic test_fwd_priority();
    int w;
    logic [DW-1:0] exp;
    ex_result = 32'd2;
    send(5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 1'b1, 3'b000, 5'd4, 1'b1, 1'b0, w);
    send(5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 1'b1, 3'b000, 5'd4, 1'b1, 1'b0, w);
    ex_result = 32'd1;
    send(5'd4, 32'h77, 5'd0, 32'd0, 32'd1, 1'b1, 3'b010, 5'd11, 1'b1, 1'b0, w);
    exp = FWD ? 32'd1 : 32'h77;
    checks++;
    if (readData1 !== exp) begin
      errors++;
      $display("FAIL fwd_priority got %0h exp %0h", readData1, exp);
    end
  endtask

  task automatic test_load_use();
    int w;
    int exp_w;
    logic [DW-1:0] exp_d;
    do_reset();
    load_data = 32'hABCD_1234;
    send(5'd0, 32'd0, 5'd0, 32'd0, 32'd4, 1'b1, 3'b000, 5'd5, 1'b1, 1'b1, w);
    send(5'd0, 32'd0, 5'd5, 32'h33, 32'd0, 1'b0, 3'b000, 5'd8, 1'b1, 1'b0, w);
    exp_w = FWD ? 2 : 3;
    exp_d = FWD ? 32'hABCD_1234 : 32'h33;
    checks++;
    if (w !== exp_w) begin
      errors++;
      $display("FAIL load_use_bubbles got %0d exp %0d", w, exp_w);
    end
    checks++;
    if (stall_cnt !== CNT_W'(exp_w)) begin
      errors++;
      $display("FAIL load_use_cnt got %0d exp %0d", stall_cnt, exp_w);
    end
    checks++;
    if (readData2 !== exp_d) begin
      errors++;
      $display("FAIL load_use_data got %0h exp %0h", readData2, exp_d);
    end
  endtask

  task automatic test_hold_flush();
    int w;
    bit c;
    do_reset();
    send(5'd1, 32'hAA, 5'd0, 32'd0, 32'h5, 1'b1, 3'b001, 5'd7, 1'b1, 1'b0, w);
    ex_ready = 0;
    id_rs_addr = 5'd2; id_rs_data = 32'h123; id_use_imm = 1; id_imm = 32'h9;
    id_rd_addr = 5'd12; id_reg_write = 1; id_mem_read = 0; id_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(c);
      checks++;
      if ({ex_valid, readData1, readData2, ALUOp} !== {1'b1, 32'hAA, 32'h5, 3'b001}) begin
        errors++;
        $display("FAIL hold got v=%b d1=%0h d2=%0h op=%0h", ex_valid, readData1, readData2, ALUOp);
      end
    end
    flush = 1;
    cycle(c);
    flush = 0;
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got %b exp 0", ex_valid);
    end
    ex_ready = 1;
    id_valid = 0;
    cycle(c);
  endtask

  task automatic test_reg_zero();
    int w;
    send(5'd1, 32'd3, 5'd0, 32'd0, 32'd0, 1'b1, 3'b000, 5'd0, 1'b1, 1'b0, w);
    ex_result = 32'hFF;
    send(5'd0, 32'd0, 5'd0, 32'd0, 32'd2, 1'b1, 3'b000, 5'd13, 1'b1, 1'b0, w);
    checks++;
    if (readData1 !== 32'd0) begin
      errors++;
      $display("FAIL reg_zero got %0h exp 0", readData1);
    end
  endtask

  task automatic test_random();
    bit c;
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs_addr   = 5'($urandom_range(0, 7));
      id_rt_addr   = 5'($urandom_range(0, 7));
      id_rd_addr   = 5'($urandom_range(0, 7));
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      id_use_imm   = 1'($urandom_range(0, 1));
      id_alu_op    = 3'($urandom_range(0, 7));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = ($urandom_range(0, 3) == 0);
      ex_result    = $urandom;
      load_data    = $urandom;
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      cycle(c);
    end
    flush = 0; ex_ready = 1; id_valid = 0;
  endtask

  task automatic test_async_reset();
    int w;
    send(5'd0, 32'd0, 5'd0, 32'd0, 32'h5A, 1'b1, 3'b111, 5'd9, 1'b1, 1'b1, w);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, readData1, readData2, ALUOp, ex_rd_addr, ex_reg_write,
         ex_mem_read, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b d2=%0h op=%0h cnt=%0d exp all zero",
               ex_valid, readData2, ALUOp, stall_cnt);
    end
    do_reset();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_ex_forward();
    test_fwd_priority();
    test_load_use();
    test_hold_flush();
    test_reg_zero();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
